// File: rtl/dense_128_weight_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dense_128_weight_fetch                                         |
// | Purpose : Read-side master for the dense_128 weight BRAM. On start it    |
// |           issues sequential word reads from base_addr_i and streams them |
// |           to the MAC array over valid/ready. A credit check on issue and |
// |           a first-word-fall-through output FIFO absorb the BRAM read     |
// |           latency and consumer back-pressure without losing data.        |
// | Ports   : clk/rst           clock, synchronous active-high reset         |
// |           start_i           one-cycle request, sampled only when idle    |
// |           base_addr_i       16-byte aligned start byte address           |
// |           num_words_i       number of words to fetch                     |
// |           busy_o/done_o     burst in progress / one-cycle completion     |
// |           err_o             one-cycle pulse for a misaligned start       |
// |           bram_*            read-only BRAM port (we/din tied to zero)    |
// |           m_valid_o/m_ready_i/m_data_o/m_last_o   output word stream     |
// |           checksum_o        XOR-fold of streamed words                   |
// | Options : DENSE_FETCH_CHECKSUM_EN enables the checksum accumulator;      |
// |           without it checksum_o is tied to zero.                         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dense_128_weight_fetch #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 128,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [CNT_W-1:0]    num_words_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [ADDR_W-1:0]   bram_addr_o,
   output logic                bram_en_o,
   output logic [DATA_W/8-1:0] bram_we_o,
   output logic [DATA_W-1:0]   bram_din_o,
   input  logic [DATA_W-1:0]   bram_dout_i,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [DATA_W-1:0]   m_data_o,
   output logic                m_last_o,
   output logic [31:0]         checksum_o
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OUT_W  = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

   generate
      if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
         $error("dense_128_weight_fetch: FIFO_DEPTH must be >= RD_LAT+2");
      end
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
         $error("dense_128_weight_fetch: RD_LAT must be in 1..3");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic                busy_q, done_q, err_q, bram_en_q;
   logic [ADDR_W-1:0]   bram_addr_q, base_q;
   logic [CNT_W-1:0]    num_q, issued_q, acc_q;
   logic [RD_LAT-1:0]   pipe_q;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0]   fifo_cnt_q;

   logic                fifo_empty, tap, push, pop, fifo_pop, start_ok, en_d;
   logic [CNT_W-1:0]    issued_d;
   logic [OUT_W-1:0]    outstanding;

   // Tap of the valid pipe marks the cycle in which bram_dout_i carries a requested word.
   assign tap        = pipe_q[RD_LAT-1];
   assign fifo_empty = (fifo_cnt_q == '0);

   // Fall-through: with an empty FIFO the arriving BRAM word is presented directly.
   // If it is not taken it is written into the FIFO and re-presented from there next cycle.
   assign m_valid_o  = !fifo_empty || tap;
   assign m_data_o   = !fifo_empty ? mem_q[rd_ptr_q] : (tap ? bram_dout_i : '0);
   assign m_last_o   = m_valid_o && (acc_q == num_q - CNT_W'(1));
   assign pop        = m_valid_o && m_ready_i;
   assign fifo_pop   = pop && !fifo_empty;
   assign push       = tap && !(fifo_empty && m_ready_i);

   assign start_ok   = (state_q == S_IDLE) && start_i && (base_addr_i[3:0] == 4'd0);

   // Credits: every read on the wire, in the latency pipe or parked in the FIFO
   // holds a FIFO slot, so a stalled consumer can never overflow the FIFO.
   always_comb begin
      outstanding = OUT_W'(bram_en_q) + OUT_W'(fifo_cnt_q);
      for (int k = 0; k < RD_LAT; k++) begin
         outstanding = outstanding + OUT_W'(pipe_q[k]);
      end
   end

   assign en_d     = (state_q == S_FETCH) && (issued_q < num_q) &&
                     (outstanding < OUT_W'(FIFO_DEPTH));
   assign issued_d = issued_q + CNT_W'(en_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         bram_en_q   <= 1'b0;
         bram_addr_q <= '0;
         base_q      <= '0;
         num_q       <= '0;
         issued_q    <= '0;
         acc_q       <= '0;
         pipe_q      <= '0;
      end else begin
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         bram_en_q <= 1'b0;
         pipe_q[0] <= bram_en_q;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
         if (pop) begin
            acc_q <= acc_q + CNT_W'(1);
         end
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (base_addr_i[3:0] != 4'd0) begin
                     err_q <= 1'b1;
                  end else if (num_words_i == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     // The first read goes out with the start: no credits are in use yet.
                     state_q     <= S_FETCH;
                     busy_q      <= 1'b1;
                     bram_en_q   <= 1'b1;
                     bram_addr_q <= base_addr_i;
                     base_q      <= base_addr_i;
                     num_q       <= num_words_i;
                     issued_q    <= CNT_W'(1);
                     acc_q       <= '0;
                  end
               end
            end
            S_FETCH: begin
               if (en_d) begin
                  bram_en_q   <= 1'b1;
                  bram_addr_q <= base_q + (ADDR_W'(issued_q) << 4);
                  issued_q    <= issued_d;
               end
               if (issued_d == num_q) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && m_last_o) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bram_dout_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         fifo_cnt_q <= fifo_cnt_q + FCNT_W'(push) - FCNT_W'(fifo_pop);
      end
   end

`ifdef DENSE_FETCH_CHECKSUM_EN
   logic [31:0] fold;
   logic [31:0] checksum_q;

   always_comb begin
      fold = '0;
      for (int k = 0; k < DATA_W / 32; k++) begin
         fold = fold ^ m_data_o[k*32 +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else if (start_ok) begin
         checksum_q <= '0;
      end else if (pop) begin
         checksum_q <= checksum_q ^ fold;
      end
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = 32'h0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign bram_en_o   = bram_en_q;
   assign bram_addr_o = bram_addr_q;
   assign bram_we_o   = '0;
   assign bram_din_o  = '0;

endmodule
`default_nettype wire
